// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812B protocol types, constants and helpers (receiver and driver).
// Rev 1.0
`default_nettype none

package ws2812_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam int BITS_PER_LED = 24;

  // Rounded to the nearest whole cycle; the 64-bit product avoids overflow at high clock rates.
  function automatic int unsigned ns_to_cycles(input int unsigned clk_freq, input int unsigned ns);
    longint unsigned prod;
    prod = 64'(clk_freq) * 64'(ns);
    return 32'((prod + 64'd500_000_000) / 64'd1_000_000_000);
  endfunction

  function automatic logic [23:0] grb_to_rgb(input logic [23:0] grb);
    return {grb[15:8], grb[23:16], grb[7:0]};
  endfunction

  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: serial input plus decoded-word/status signals of the WS2812B receiver.
// Rev 1.0
`default_nettype none

interface ws2812_rx_if;
  logic        led_in;
  logic [23:0] rgb_data;
  logic        rgb_valid;
  logic        frame_end;
  logic        rx_error;
  logic        busy;
  logic        led_fwd;

  modport master (
    input  led_in,
    output rgb_data, rgb_valid, frame_end, rx_error, busy, led_fwd
  );

  modport slave (
    output led_in,
    input  rgb_data, rgb_valid, frame_end, rx_error, busy, led_fwd
  );
endinterface

`default_nettype wire

// File: rtl/ws2812_in_sync.sv
// ws2812_in_sync: two-flop synchronizer for the LED line with single-cycle rise/fall strobes.
// Rev 1.0
`default_nettype none

module ws2812_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic stage1;
  logic stage2;
  logic delayed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1  <= 1'b0;
      stage2  <= 1'b0;
      delayed <= 1'b0;
    end else begin
      stage1  <= din;
      stage2  <= stage1;
      delayed <= stage2;
    end
  end

  assign level = stage2;
  assign rise  = stage2 & ~delayed;
  assign fall  = ~stage2 & delayed;

endmodule

`default_nettype wire

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812B receiver; classifies high pulses, assembles GRB words, emits {R,G,B}.
// Rev 1.0
`default_nettype none

module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int CLK_FREQ     = 27_000_000,
  parameter int CASCADE      = 0,
  parameter int THRESH_NS    = 600,
  parameter int MIN_HIGH_NS  = 150,
  parameter int MAX_HIGH_NS  = 2000,
  parameter int RESET_DET_NS = 40000
) (
  input logic         clk,
  input logic         rst,
  ws2812_rx_if.master bus
);

  localparam logic [15:0] THRESH    = 16'(ns_to_cycles(CLK_FREQ, THRESH_NS));
  localparam logic [15:0] MIN_HIGH  = 16'(ns_to_cycles(CLK_FREQ, MIN_HIGH_NS));
  localparam logic [15:0] MAX_HIGH  = 16'(ns_to_cycles(CLK_FREQ, MAX_HIGH_NS));
  localparam logic [15:0] RESET_DET = 16'(ns_to_cycles(CLK_FREQ, RESET_DET_NS));
  localparam logic [4:0]  LAST_BIT  = 5'(BITS_PER_LED - 1);

  logic s_level, s_rise, s_fall;

  ws2812_in_sync u_in_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.led_in),
    .level (s_level),
    .rise  (s_rise),
    .fall  (s_fall)
  );

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx, cnt_inc;
  logic [4:0]  bitcnt, bitcnt_nx;
  logic [23:0] sr, sr_nx, sr_shift;
  logic [23:0] rgb, rgb_nx;
  logic        valid, valid_nx;
  logic        fend, fend_nx;
  logic        err, err_nx;
  logic        fwd_active, fwd_active_nx;
  logic        fwd;

  assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign sr_shift = {sr[22:0], (cnt >= THRESH)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SYNC;
      cnt        <= '0;
      bitcnt     <= '0;
      sr         <= '0;
      rgb        <= '0;
      valid      <= 1'b0;
      fend       <= 1'b0;
      err        <= 1'b0;
      fwd_active <= 1'b0;
      fwd        <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bitcnt     <= bitcnt_nx;
      sr         <= sr_nx;
      rgb        <= rgb_nx;
      valid      <= valid_nx;
      fend       <= fend_nx;
      err        <= err_nx;
      fwd_active <= fwd_active_nx;
      fwd        <= s_level & fwd_active;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    bitcnt_nx     = bitcnt;
    sr_nx         = sr;
    rgb_nx        = rgb;
    valid_nx      = 1'b0;
    fend_nx       = 1'b0;
    err_nx        = 1'b0;
    fwd_active_nx = fwd_active;

    case (state)
      // Only a full latch-length low proves we are between frames.
      SYNC: begin
        if (s_level) begin
          cnt_nx = '0;
        end else if (cnt_inc >= RESET_DET) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end

      IDLE: begin
        if (s_rise) begin
          state_nx = HIGH;
          cnt_nx   = 16'd1;
        end
      end

      HIGH: begin
        if (s_fall && cnt >= MIN_HIGH) begin
          sr_nx    = sr_shift;
          state_nx = LOW;
          cnt_nx   = 16'd1;
          if (bitcnt == LAST_BIT) begin
            bitcnt_nx = '0;
            if (CASCADE == 0 || !fwd_active) begin
              rgb_nx   = grb_to_rgb(sr_shift);
              valid_nx = 1'b1;
            end
            if (CASCADE != 0) begin
              fwd_active_nx = 1'b1;
            end
          end else begin
            bitcnt_nx = bitcnt + 5'd1;
          end
        end else if (s_fall || cnt_inc >= MAX_HIGH) begin
          err_nx        = 1'b1;
          bitcnt_nx     = '0;
          fwd_active_nx = 1'b0;
          state_nx      = SYNC;
          cnt_nx        = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end

      LOW: begin
        if (s_rise) begin
          state_nx = HIGH;
          cnt_nx   = 16'd1;
        end else if (cnt_inc >= RESET_DET) begin
          fend_nx       = 1'b1;
          err_nx        = (bitcnt != 5'd0);
          bitcnt_nx     = '0;
          fwd_active_nx = 1'b0;
          state_nx      = IDLE;
          cnt_nx        = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end

      default: begin
        state_nx = SYNC;
        cnt_nx   = '0;
      end
    endcase
  end

  assign bus.rgb_data  = rgb;
  assign bus.rgb_valid = valid;
  assign bus.frame_end = fend;
  assign bus.rx_error  = err;
  assign bus.busy      = (state == HIGH) || (state == LOW);
  assign bus.led_fwd   = fwd;

endmodule

`default_nettype wire

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx, one plain (CASCADE=0) and one cascade (CASCADE=1) instance.
// Rev 1.0
`default_nettype none

module tb_ws2812_rx;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic line = 1'b0;

  always #5 clk = ~clk;

  ws2812_rx_if bus0 ();
  ws2812_rx_if bus1 ();
  assign bus0.led_in = line;
  assign bus1.led_in = line;

  ws2812_rx #(.CASCADE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ws2812_rx #(.CASCADE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int nchk = 0;
  int npass = 0;

  // Cycle index: becomes n at the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nv0 = 0, nf0 = 0, ne0 = 0, nv1 = 0;
  int vcyc0 = 0, fcyc0 = 0, ecyc0 = 0;
  logic [23:0] vdata0 = '0, vdata1 = '0;
  int fwd_bad = 0, fr0 = 0, fr1 = 0;
  logic fp0 = 1'b0, fp1 = 1'b0;
  logic [3:0] lh = '0;
  bit fwd_chk = 1'b0, fwd_zero = 1'b0;
  int last_fall = 0;

  always @(negedge clk) begin
    if (bus0.rgb_valid) begin nv0 <= nv0 + 1; vcyc0 <= cyc; vdata0 <= bus0.rgb_data; end
    if (bus0.frame_end) begin nf0 <= nf0 + 1; fcyc0 <= cyc; end
    if (bus0.rx_error)  begin ne0 <= ne0 + 1; ecyc0 <= cyc; end
    if (bus1.rgb_valid) begin nv1 <= nv1 + 1; vdata1 <= bus1.rgb_data; end
    // lh[2] (pre-update) holds the line value driven three cycles earlier.
    lh <= {lh[2:0], line};
    if (fwd_chk && bus1.led_fwd !== lh[2]) fwd_bad <= fwd_bad + 1;
    if (fwd_zero && bus1.led_fwd !== 1'b0) fwd_bad <= fwd_bad + 1;
    if (bus0.led_fwd && !fp0) fr0 <= fr0 + 1;
    if (bus1.led_fwd && !fp1) fr1 <= fr1 + 1;
    fp0 <= bus0.led_fwd;
    fp1 <= bus1.led_fwd;
  end

  task automatic drive(input logic v, input int n);
    line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int hi, input int lo);
    drive(1'b1, hi);
    last_fall = cyc;
    drive(1'b0, lo);
  endtask

  // Sends the top nbits of w MSB first with a 34-cycle bit period.
  task automatic send_word(input logic [23:0] w, input int nbits, input int h0, input int h1);
    for (int i = 23; i > 23 - nbits; i--) begin
      if (w[i]) send_bit(h1, 34 - h1);
      else      send_bit(h0, 34 - h0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; line = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nchk++; if (bus0.rgb_data !== 24'h0) $display("FAIL reset_rgb_data: got %h want 000000", bus0.rgb_data); else npass++;
    nchk++; if (bus0.rgb_valid !== 1'b0) $display("FAIL reset_rgb_valid: got %b want 0", bus0.rgb_valid); else npass++;
    nchk++; if (bus0.frame_end !== 1'b0) $display("FAIL reset_frame_end: got %b want 0", bus0.frame_end); else npass++;
    nchk++; if (bus0.rx_error !== 1'b0) $display("FAIL reset_rx_error: got %b want 0", bus0.rx_error); else npass++;
    nchk++; if (bus0.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus0.busy); else npass++;
    nchk++; if (bus1.led_fwd !== 1'b0) $display("FAIL reset_led_fwd: got %b want 0", bus1.led_fwd); else npass++;
    rst = 1'b0;
    drive(1'b0, 1100);
    nchk++; if (bus0.busy !== 1'b0) $display("FAIL sync_busy: got %b want 0", bus0.busy); else npass++;
    nchk++; if (nf0 !== 0) $display("FAIL sync_no_frame_end: got %0d want 0", nf0); else npass++;
  endtask

  task automatic test_frame;
    int v, f, e, fl;
    v = nv0; f = nf0; e = ne0;
    send_word(24'h80FF01, 24, 11, 22);
    fl = last_fall;
    drive(1'b0, 1200);
    nchk++; if (nv0 - v !== 1) $display("FAIL frame_valid_count: got %0d want 1", nv0 - v); else npass++;
    nchk++; if (vdata0 !== 24'hFF8001) $display("FAIL frame_rgb_data: got %h want ff8001", vdata0); else npass++;
    nchk++; if (vcyc0 !== fl + 3) $display("FAIL frame_valid_latency: got %0d want %0d", vcyc0 - fl, 3); else npass++;
    nchk++; if (nf0 - f !== 1) $display("FAIL frame_end_count: got %0d want 1", nf0 - f); else npass++;
    nchk++; if (fcyc0 !== fl + 1082) $display("FAIL frame_end_time: got %0d want %0d", fcyc0 - fl, 1082); else npass++;
    nchk++; if (ne0 - e !== 0) $display("FAIL frame_no_error: got %0d want 0", ne0 - e); else npass++;
  endtask

  task automatic test_glitch;
    int v, f, e;
    v = nv0; f = nf0; e = ne0;
    send_word(24'hF00000, 5, 11, 22);
    send_bit(3, 31);
    send_word(24'hFFFFFF, 18, 11, 22);
    drive(1'b0, 1200);
    nchk++; if (ne0 - e !== 1) $display("FAIL glitch_error_count: got %0d want 1", ne0 - e); else npass++;
    nchk++; if (nv0 - v !== 0) $display("FAIL glitch_ignored_valid: got %0d want 0", nv0 - v); else npass++;
    nchk++; if (nf0 - f !== 0) $display("FAIL glitch_no_frame_end: got %0d want 0", nf0 - f); else npass++;
    send_word(24'h341256, 24, 11, 22);
    drive(1'b0, 1200);
    nchk++; if (nv0 - v !== 1) $display("FAIL recover_valid_count: got %0d want 1", nv0 - v); else npass++;
    nchk++; if (vdata0 !== 24'h123456) $display("FAIL recover_rgb_data: got %h want 123456", vdata0); else npass++;
    nchk++; if (nf0 - f !== 1) $display("FAIL recover_frame_end: got %0d want 1", nf0 - f); else npass++;
  endtask

  task automatic test_overlong;
    int f, e, k;
    f = nf0; e = ne0; k = cyc;
    line = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    nchk++; if (bus0.busy !== 1'b1) $display("FAIL long_busy_high: got %b want 1", bus0.busy); else npass++;
    repeat (10) @(posedge clk);
    #1;
    nchk++; if (ne0 - e !== 1) $display("FAIL long_error_count: got %0d want 1", ne0 - e); else npass++;
    nchk++; if (ecyc0 !== k + 56) $display("FAIL long_error_time: got %0d want %0d", ecyc0 - k, 56); else npass++;
    nchk++; if (bus0.busy !== 1'b0) $display("FAIL long_busy_drop: got %b want 0", bus0.busy); else npass++;
    drive(1'b0, 100);
    line = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    nchk++; if (bus0.busy !== 1'b0) $display("FAIL long_stays_sync: got %b want 0", bus0.busy); else npass++;
    drive(1'b0, 1200);
    nchk++; if (nf0 - f !== 0) $display("FAIL long_no_frame_end: got %0d want 0", nf0 - f); else npass++;
    nchk++; if (ne0 - e !== 1) $display("FAIL long_single_error: got %0d want 1", ne0 - e); else npass++;
  endtask

  task automatic test_partial;
    int v, f, e, fl;
    v = nv0; f = nf0; e = ne0;
    send_word(24'hABC000, 12, 11, 22);
    fl = last_fall;
    drive(1'b0, 1200);
    nchk++; if (nf0 - f !== 1) $display("FAIL partial_frame_end: got %0d want 1", nf0 - f); else npass++;
    nchk++; if (ne0 - e !== 1) $display("FAIL partial_error: got %0d want 1", ne0 - e); else npass++;
    nchk++; if (ecyc0 !== fcyc0) $display("FAIL partial_same_cycle: got err %0d want %0d", ecyc0, fcyc0); else npass++;
    nchk++; if (fcyc0 !== fl + 1082) $display("FAIL partial_end_time: got %0d want %0d", fcyc0 - fl, 1082); else npass++;
    nchk++; if (nv0 - v !== 0) $display("FAIL partial_no_valid: got %0d want 0", nv0 - v); else npass++;
  endtask

  task automatic test_boundary;
    int v, e;
    v = nv0; e = ne0;
    send_word(24'h0FF0AA, 24, 15, 16);
    drive(1'b0, 1200);
    nchk++; if (nv0 - v !== 1) $display("FAIL bound_valid_count: got %0d want 1", nv0 - v); else npass++;
    nchk++; if (vdata0 !== 24'hF00FAA) $display("FAIL bound_rgb_data: got %h want f00faa", vdata0); else npass++;
    nchk++; if (ne0 - e !== 0) $display("FAIL bound_no_error: got %0d want 0", ne0 - e); else npass++;
  endtask

  task automatic test_back_to_back;
    int v0, v1, f, r0, r1, bad;
    v0 = nv0; v1 = nv1; f = nf0; r0 = fr0; r1 = fr1; bad = fwd_bad;
    fwd_zero = 1'b1;
    send_word(24'h00FF00, 24, 11, 22);
    fwd_zero = 1'b0;
    fwd_chk = 1'b1;
    send_word(24'h5A3C81, 24, 11, 22);
    send_word(24'hC30F7E, 24, 11, 22);
    fwd_chk = 1'b0;
    drive(1'b0, 1200);
    nchk++; if (nv0 - v0 !== 3) $display("FAIL b2b_valid_count: got %0d want 3", nv0 - v0); else npass++;
    nchk++; if (vdata0 !== 24'h0FC37E) $display("FAIL b2b_last_rgb: got %h want 0fc37e", vdata0); else npass++;
    nchk++; if (nf0 - f !== 1) $display("FAIL b2b_frame_end: got %0d want 1", nf0 - f); else npass++;
    nchk++; if (nv1 - v1 !== 1) $display("FAIL cascade_valid_count: got %0d want 1", nv1 - v1); else npass++;
    nchk++; if (vdata1 !== 24'hFF0000) $display("FAIL cascade_rgb_data: got %h want ff0000", vdata1); else npass++;
    nchk++; if (fr1 - r1 !== 48) $display("FAIL cascade_fwd_pulses: got %0d want 48", fr1 - r1); else npass++;
    nchk++; if (fwd_bad - bad !== 0) $display("FAIL cascade_fwd_shape: got %0d bad cycles want 0", fwd_bad - bad); else npass++;
    nchk++; if (fr0 - r0 !== 0) $display("FAIL plain_fwd_idle: got %0d pulses want 0", fr0 - r0); else npass++;
  endtask

  task automatic test_reset_mid;
    int v, e;
    send_word(24'h123456, 10, 11, 22);
    line = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    nchk++; if (bus0.busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", bus0.busy); else npass++;
    rst = 1'b1;
    #1;
    nchk++; if (bus0.rgb_data !== 24'h0) $display("FAIL mid_rgb0: got %h want 000000", bus0.rgb_data); else npass++;
    nchk++; if (bus1.rgb_data !== 24'h0) $display("FAIL mid_rgb1: got %h want 000000", bus1.rgb_data); else npass++;
    nchk++; if (bus0.busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus0.busy); else npass++;
    nchk++; if ({bus0.rgb_valid, bus0.frame_end, bus0.rx_error} !== 3'b000) $display("FAIL mid_pulses: got %b want 000", {bus0.rgb_valid, bus0.frame_end, bus0.rx_error}); else npass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1200);
    v = nv0; e = ne0;
    send_word(24'h00AA55, 24, 11, 22);
    drive(1'b0, 1200);
    nchk++; if (nv0 - v !== 1) $display("FAIL mid_after_valid: got %0d want 1", nv0 - v); else npass++;
    nchk++; if (vdata0 !== 24'hAA0055) $display("FAIL mid_after_rgb: got %h want aa0055", vdata0); else npass++;
    nchk++; if (ne0 - e !== 0) $display("FAIL mid_after_error: got %0d want 0", ne0 - e); else npass++;
  endtask

  initial begin
    test_reset;
    test_frame;
    test_glitch;
    test_overlong;
    test_partial;
    test_boundary;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

`default_nettype wire
